// File: rtl/joy_input_filter.sv
// Per-bit debounce and optional fire autofire for the two joystick ports.
// Ports: clk, rst (async, active-high), ready, joya_in/joyb_in (active-low
//   {fire2,fire,up,down,left,right}), af_en_a/af_en_b autofire enables,
//   joya_out/joyb_out registered filtered words, changed one-cycle strobe.
module joy_input_filter #(
  parameter int DEBOUNCE_CYCLES = 28000,
  parameter int CNT_W           = 15,
  parameter int AUTOFIRE_DIV    = 700000,
  parameter int AF_W            = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [5:0] joya_in,
  input  logic [5:0] joyb_in,
  input  logic       af_en_a,
  input  logic       af_en_b,
  output logic [5:0] joya_out,
  output logic [5:0] joyb_out,
  output logic       changed
);

  localparam logic [CNT_W-1:0] DB_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AF_W-1:0] AF_MAX =
    AF_W'(AUTOFIRE_DIV - 1);

  // Port A occupies bits 5:0, port B bits 11:6.
  logic [11:0]      in_q;
  logic             ready_q;
  logic [1:0]       af_en_q;

  logic [11:0]      db_q, db_d;
  logic [CNT_W-1:0] cnt_q [12];
  logic [CNT_W-1:0] cnt_d [12];

  logic [AF_W-1:0]  af_cnt_q [2];
  logic [AF_W-1:0]  af_cnt_d [2];
  logic [1:0]       af_ph_q, af_ph_d;
  logic [1:0]       fire_eff;
  logic [1:0]       fire_db;

  logic [5:0]       joya_q, joya_d;
  logic [5:0]       joyb_q, joyb_d;
  logic             changed_q, changed_d;

  assign fire_db = {db_q[10], db_q[4]};

  // A sample equal to the filtered value restarts the count, so only
  // an unbroken run of DEBOUNCE_CYCLES differing samples gets through.
  always_comb begin
    for (int i = 0; i < 12; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = cnt_q[i];
      if (!ready_q) begin
        db_d[i]  = 1'b1;
        cnt_d[i] = '0;
      end else if (in_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_MAX) begin
        db_d[i]  = in_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Phase 0 reads as pressed, so a fresh press fires at once.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      af_cnt_d[p] = af_cnt_q[p];
      af_ph_d[p]  = af_ph_q[p];
      if (!ready_q || !af_en_q[p] || fire_db[p]) begin
        af_cnt_d[p] = '0;
        af_ph_d[p]  = 1'b0;
      end else if (af_cnt_q[p] == AF_MAX) begin
        af_cnt_d[p] = '0;
        af_ph_d[p]  = ~af_ph_q[p];
      end else begin
        af_cnt_d[p] = af_cnt_q[p] + AF_W'(1);
      end
      fire_eff[p] = af_en_q[p] ?
        (fire_db[p] | af_ph_q[p]) : fire_db[p];
    end
  end

  always_comb begin
    joya_d = 6'h3F;
    joyb_d = 6'h3F;
    if (ready_q) begin
      joya_d = {db_q[5], fire_eff[0], db_q[3:0]};
      joyb_d = {db_q[11], fire_eff[1], db_q[9:6]};
    end
    changed_d = (joya_d != joya_q) ||
                (joyb_d != joyb_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q      <= 12'hFFF;
      ready_q   <= 1'b0;
      af_en_q   <= 2'b00;
      db_q      <= 12'hFFF;
      for (int i = 0; i < 12; i++)
        cnt_q[i] <= '0;
      for (int p = 0; p < 2; p++)
        af_cnt_q[p] <= '0;
      af_ph_q   <= 2'b00;
      joya_q    <= 6'h3F;
      joyb_q    <= 6'h3F;
      changed_q <= 1'b0;
    end else begin
      in_q      <= {joyb_in, joya_in};
      ready_q   <= ready;
      af_en_q   <= {af_en_b, af_en_a};
      db_q      <= db_d;
      for (int i = 0; i < 12; i++)
        cnt_q[i] <= cnt_d[i];
      for (int p = 0; p < 2; p++)
        af_cnt_q[p] <= af_cnt_d[p];
      af_ph_q   <= af_ph_d;
      joya_q    <= joya_d;
      joyb_q    <= joyb_d;
      changed_q <= changed_d;
    end
  end

  assign joya_out = joya_q;
  assign joyb_out = joyb_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_joy_input_filter.sv
// Scoreboard bench for joy_input_filter: directed scenarios plus random
// stimulus against a history-based reference model.
module tb_joy_input_filter;

  localparam int DEB = 4;
  localparam int DIV = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b0;
  logic [5:0] joya_in = 6'h3F;
  logic [5:0] joyb_in = 6'h3F;
  logic       af_en_a = 1'b0;
  logic       af_en_b = 1'b0;
  logic [5:0] joya_out;
  logic [5:0] joyb_out;
  logic       changed;

  always #5 clk = ~clk;

  joy_input_filter #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(15),
    .AUTOFIRE_DIV(DIV),
    .AF_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ready(ready),
    .joya_in(joya_in),
    .joyb_in(joyb_in),
    .af_en_a(af_en_a),
    .af_en_b(af_en_b),
    .joya_out(joya_out),
    .joyb_out(joyb_out),
    .changed(changed)
  );

  typedef struct packed {
    logic [11:0] d;
    logic        rdy;
    logic [1:0]  en;
  } samp_t;

  // hist[$] is the sample currently held in the input registers.
  samp_t       hist[$];
  logic [11:0] m_db;
  int          m_run [2];
  logic [5:0]  m_a, m_b;
  logic [12:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  function automatic void model_reset();
    samp_t s;
    s.d = 12'hFFF;
    s.rdy = 1'b0;
    s.en = 2'b00;
    hist.delete();
    for (int k = 0; k <= DEB; k++)
      hist.push_back(s);
    m_db = 12'hFFF;
    m_run[0] = 0;
    m_run[1] = 0;
    m_a = 6'h3F;
    m_b = 6'h3F;
  endfunction

  function automatic void model_edge(samp_t cur);
    samp_t       r, s;
    logic [11:0] ndb;
    logic [5:0]  na, nb;
    logic [1:0]  fire;
    logic        ch, ph, all;
    int          fi;
    r = hist[$];
    for (int p = 0; p < 2; p++) begin
      fi = p * 6 + 4;
      ph = ((m_run[p] / DIV) % 2) == 1;
      fire[p] = r.en[p] ? (m_db[fi] | ph) : m_db[fi];
    end
    na = r.rdy ? {m_db[5], fire[0], m_db[3:0]} : 6'h3F;
    nb = r.rdy ? {m_db[11], fire[1], m_db[9:6]} : 6'h3F;
    ch = (na != m_a) || (nb != m_b);
    ndb = m_db;
    if (!r.rdy) begin
      ndb = 12'hFFF;
    end else begin
      for (int i = 0; i < 12; i++) begin
        all = 1'b1;
        for (int j = 1; j <= DEB; j++) begin
          s = hist[hist.size() - j];
          if (!s.rdy || s.d[i] == m_db[i])
            all = 1'b0;
        end
        if (all)
          ndb[i] = ~m_db[i];
      end
    end
    // Phase after n counted edges is (n / DIV) mod 2.
    for (int p = 0; p < 2; p++) begin
      fi = p * 6 + 4;
      if (r.rdy && r.en[p] && !m_db[fi])
        m_run[p] = m_run[p] + 1;
      else
        m_run[p] = 0;
    end
    m_db = ndb;
    m_a = na;
    m_b = nb;
    hist.push_back(cur);
    if (hist.size() > DEB + 1)
      void'(hist.pop_front());
    exp_q.push_back({na, nb, ch});
  endfunction

  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({joya_out, joyb_out, changed} !== e) begin
        errors++;
        $display("FAIL sb cyc=%0d got a=%h b=%h ch=%b exp a=%h b=%h ch=%b",
                 cyc, joya_out, joyb_out, changed,
                 e[12:7], e[6:1], e[0]);
      end
      cyc++;
    end
  end

  task automatic step(input logic [5:0] a, input logic [5:0] b,
                      input logic rdy, input logic ea,
                      input logic eb);
    samp_t s;
    @(negedge clk);
    rst = 1'b0;
    joya_in = a;
    joyb_in = b;
    ready = rdy;
    af_en_a = ea;
    af_en_b = eb;
    s.d = {b, a};
    s.rdy = rdy;
    s.en = {eb, ea};
    @(posedge clk);
    model_edge(s);
  endtask

  task automatic hold(input int n, input logic [5:0] a,
                      input logic [5:0] b, input logic rdy,
                      input logic ea, input logic eb);
    for (int k = 0; k < n; k++)
      step(a, b, rdy, ea, eb);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({joya_out, joyb_out, changed} !== {6'h3F, 6'h3F, 1'b0}) begin
      errors++;
      $display("FAIL async_rst got a=%h b=%h ch=%b exp 3f 3f 0",
               joya_out, joyb_out, changed);
    end
    model_reset();
    @(posedge clk);
    exp_q.push_back({6'h3F, 6'h3F, 1'b0});
  endtask

  logic [5:0] ra, rb;
  logic       rr, rea, reb;

  initial begin
    model_reset();
    do_reset();
    // basic debounce of right on port A
    hold(4, 6'h3F, 6'h3F, 1, 0, 0);
    hold(10, 6'h3E, 6'h3F, 1, 0, 0);
    hold(10, 6'h3F, 6'h3F, 1, 0, 0);
    // short glitch is rejected
    hold(3, 6'h3E, 6'h3F, 1, 0, 0);
    hold(10, 6'h3F, 6'h3F, 1, 0, 0);
    // autofire on port A
    hold(20, 6'h2F, 6'h3F, 1, 1, 0);
    hold(10, 6'h3F, 6'h3F, 1, 1, 0);
    hold(4, 6'h3F, 6'h3F, 1, 0, 0);
    // ready drop while port B is held
    hold(10, 6'h3F, 6'h30, 1, 0, 0);
    hold(5, 6'h3F, 6'h30, 0, 0, 0);
    hold(10, 6'h3F, 6'h30, 1, 0, 0);
    hold(10, 6'h3F, 6'h3F, 1, 0, 0);
    // reset mid-count
    hold(2, 6'h3E, 6'h3F, 1, 0, 0);
    do_reset();
    hold(10, 6'h3E, 6'h3F, 1, 0, 0);
    // reset mid-autofire
    hold(10, 6'h2F, 6'h3F, 1, 1, 0);
    do_reset();
    hold(12, 6'h2F, 6'h3F, 1, 1, 0);
    hold(8, 6'h3F, 6'h3F, 1, 0, 0);
    // both ports change on the same edge
    hold(10, 6'h3A, 6'h35, 1, 0, 0);
    hold(10, 6'h3F, 6'h3F, 1, 0, 0);
    // random traffic
    ra = 6'h3F;
    rb = 6'h3F;
    rr = 1'b1;
    rea = 1'b0;
    reb = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0)
        ra[$urandom_range(0, 5)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0)
        rb[$urandom_range(0, 5)] ^= 1'b1;
      if (rr ? ($urandom_range(0, 149) == 0)
             : ($urandom_range(0, 9) == 0))
        rr = ~rr;
      if ($urandom_range(0, 49) == 0)
        rea = ~rea;
      if ($urandom_range(0, 49) == 0)
        reb = ~reb;
      if ($urandom_range(0, 499) == 0)
        do_reset();
      step(ra, rb, rr, rea, reb);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
